// File: rtl/spi_regs_ctrl.sv
// spi_regs_ctrl: SPI mode-0 slave to 4-byte register bank (0 LED rw, 1 SCRATCH rw, 2 ID ro, 3 WRCNT ro); ports clk_i/rst_i, spi_sck_i/spi_cs_i/spi_mosi_i in, spi_miso_o, led_o, wr_stb_o/wr_addr_o/wr_data_o out; define SPI_REGS_CTRL_BURST_EN for per-byte address auto-increment.
module spi_regs_ctrl #(
  parameter int ADDR_W = 2,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_cs_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic [7:0]        led_o,
  output logic              wr_stb_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state;
  logic [2:0] sck_p, cs_p;
  logic [1:0] mosi_p, settle;
  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_b, armed, rw, byte_done, wr_ok;
  logic [2:0] cnt;
  logic [7:0] rx, tx, scratch, wrcnt, byte_in, rd_data;
  logic [ADDR_W-1:0] addr, cmd_addr, next_addr, rd_addr;
  always_comb begin
    byte_in = {rx[6:0], mosi_b};
    byte_done = sck_rise && cnt == 3'd7;
    cmd_addr = byte_in[ADDR_W-1:0];
`ifdef SPI_REGS_CTRL_BURST_EN
    next_addr = addr + ADDR_W'(1);
`else
    next_addr = addr;
`endif
    rd_addr = (state == CMD) ? cmd_addr : next_addr;
    rd_data = (rd_addr == ADDR_W'(0)) ? led_o :
              (rd_addr == ADDR_W'(1)) ? scratch :
              (rd_addr == ADDR_W'(2)) ? ID_VALUE :
              (rd_addr == ADDR_W'(3)) ? wrcnt : 8'h00;
    wr_ok = addr < ADDR_W'(2);
  end
  assign spi_miso_o = (state == DATA && rw) ? tx[7] : 1'b0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_p <= 3'b000;
      cs_p <= 3'b111;
      mosi_p <= 2'b00;
      {sck_rise, sck_fall, cs_rise, cs_fall, mosi_b} <= '0;
      settle <= 2'd0;
      armed <= 1'b0;
      state <= IDLE;
      cnt <= 3'd0;
      rx <= 8'h00;
      tx <= 8'h00;
      rw <= 1'b0;
      addr <= '0;
      led_o <= 8'h00;
      scratch <= 8'h00;
      wrcnt <= 8'h00;
      wr_stb_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= 8'h00;
    end else begin
      sck_p <= {sck_p[1:0], spi_sck_i};
      cs_p <= {cs_p[1:0], spi_cs_i};
      mosi_p <= {mosi_p[0], spi_mosi_i};
      sck_rise <= sck_p[1] & ~sck_p[2];
      sck_fall <= ~sck_p[1] & sck_p[2];
      cs_rise <= cs_p[1] & ~cs_p[2];
      cs_fall <= ~cs_p[1] & cs_p[2];
      mosi_b <= mosi_p[1];
      // cs pipeline holds its reset value for two cycles, so arming waits until it reflects the pin
      settle <= settle + {1'b0, settle != 2'd3};
      armed <= armed | (cs_p[1] & (settle == 2'd3));
      wr_stb_o <= 1'b0;
      if (cs_rise)
        state <= IDLE;
      else if (state == IDLE) begin
        if (cs_fall && armed) begin
          state <= CMD;
          cnt <= 3'd0;
        end
      end else if (sck_rise) begin
        rx <= byte_in;
        cnt <= cnt + 3'd1;
        if (byte_done) begin
          tx <= rd_data;
          if (state == CMD) begin
            rw <= byte_in[7];
            addr <= cmd_addr;
            state <= DATA;
          end else begin
            addr <= next_addr;
            if (!rw && wr_ok) begin
              if (addr == ADDR_W'(0)) led_o <= byte_in;
              if (addr == ADDR_W'(1)) scratch <= byte_in;
              wrcnt <= wrcnt + 8'd1;
              wr_stb_o <= 1'b1;
              wr_addr_o <= addr;
              wr_data_o <= byte_in;
            end
          end
        end
      end else if (sck_fall && state == DATA && cnt != 3'd0)
        // the fall right after a byte boundary keeps the freshly loaded bit7 on the line
        tx <= {tx[6:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_spi_regs_ctrl.sv
// tb_spi_regs_ctrl: vector table, random frames against a register-map model, abort and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_spi_regs_ctrl;
  typedef struct {
    int n;
    logic [3:0][7:0] b;
    logic [7:0] e_led;
    int e_nstb;
    logic [7:0] e_rd;
  } vec_t;
  logic clk = 0, rst = 1, sck = 0, cs = 1, mosi = 0;
  logic miso, stb;
  logic [7:0] led, wdata;
  logic [1:0] waddr;
  logic [7:0] m_led = 0, m_scr = 0, m_cnt = 0;
  logic [9:0] exp_q[$], obs_q[$];
  int total = 0, bad = 0, hp = 70;
  vec_t vt[7];
  always #5 clk = ~clk;
  spi_regs_ctrl dut (
    .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_i(cs), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .led_o(led), .wr_stb_o(stb), .wr_addr_o(waddr), .wr_data_o(wdata)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && stb) begin
      obs_q.push_back({waddr, wdata});
      if (waddr == 2'd0) chk("led_at_stb", 32'(led), 32'(wdata));
    end
  function automatic logic [7:0] m_rd(input logic [1:0] a);
    return a == 2'd0 ? m_led : a == 2'd1 ? m_scr : a == 2'd2 ? 8'hA5 : m_cnt;
  endfunction
  task automatic model_frame(input logic [3:0][7:0] b, input int n, output logic [3:0][7:0] em);
    logic rw;
    logic [1:0] a;
    rw = b[0][7];
    a = b[0][1:0];
    em = '0;
    for (int i = 1; i < n; i++) begin
      if (rw) em[i] = m_rd(a);
      else if (a < 2'd2) begin
        if (a == 2'd0) m_led = b[i];
        else m_scr = b[i];
        m_cnt++;
        exp_q.push_back({a, b[i]});
      end
`ifdef SPI_REGS_CTRL_BURST_EN
      a++;
`endif
    end
  endtask
  task automatic shift_byte(input logic [7:0] d, input int nb, output logic [7:0] got);
    got = '0;
    for (int k = 7; k > 7 - nb; k--) begin
      mosi = d[k];
      #(hp);
      got[k] = miso;
      sck = 1;
      #(hp);
      sck = 0;
    end
  endtask
  task automatic frame(input logic [3:0][7:0] b, input int n, input int extra, output logic [3:0][7:0] got);
    logic [7:0] g;
    got = '0;
    hp = $urandom_range(60, 90);
    cs = 0;
    #(hp);
    for (int i = 0; i < n; i++) begin
      shift_byte(b[i], 8, g);
      got[i] = g;
    end
    if (extra > 0) shift_byte(b[n], extra, g);
    #(hp);
    cs = 1;
    mosi = 0;
    repeat (12) @(posedge clk);
  endtask
  task automatic check_stbs(input string name);
    chk({name, "_nstb"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({name, "_stb"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic run_frame(input string name, input logic [3:0][7:0] b, input int n,
                           output logic [3:0][7:0] got, output int nstb);
    logic [3:0][7:0] em;
    model_frame(b, n, em);
    frame(b, n, 0, got);
    for (int i = 0; i < n; i++) chk($sformatf("%s_miso%0d", name, i), 32'(got[i]), 32'(em[i]));
    chk({name, "_led"}, 32'(led), 32'(m_led));
    nstb = obs_q.size();
    check_stbs(name);
  endtask
  initial begin
    logic [3:0][7:0] got, b;
    logic [7:0] g;
    int nstb, n;
    vt[0] = '{2, {8'h00, 8'h00, 8'h00, 8'h83}, 8'h00, 0, 8'h00};
    vt[1] = '{2, {8'h00, 8'h00, 8'h3C, 8'h00}, 8'h3C, 1, 8'h00};
    vt[2] = '{2, {8'h00, 8'h00, 8'h00, 8'h83}, 8'h3C, 0, 8'h01};
    vt[3] = '{2, {8'h00, 8'h00, 8'h00, 8'h82}, 8'h3C, 0, 8'hA5};
`ifdef SPI_REGS_CTRL_BURST_EN
    vt[4] = '{4, {8'h33, 8'h22, 8'h11, 8'h00}, 8'h11, 2, 8'h00};
    vt[5] = '{2, {8'h00, 8'h00, 8'h00, 8'h83}, 8'h11, 0, 8'h03};
    vt[6] = '{2, {8'h00, 8'h00, 8'h00, 8'h81}, 8'h11, 0, 8'h22};
`else
    vt[4] = '{4, {8'h33, 8'h22, 8'h11, 8'h00}, 8'h33, 3, 8'h00};
    vt[5] = '{2, {8'h00, 8'h00, 8'h00, 8'h83}, 8'h33, 0, 8'h04};
    vt[6] = '{2, {8'h00, 8'h00, 8'h00, 8'h81}, 8'h33, 0, 8'h00};
`endif
    repeat (5) @(posedge clk);
    #1 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_led", 32'(led), 32'h00);
    chk("reset_miso", 32'(miso), 32'h0);
    chk("reset_nstb", 32'(obs_q.size()), 32'h0);
    for (int v = 0; v < 7; v++) begin
      run_frame($sformatf("vec%0d", v), vt[v].b, vt[v].n, got, nstb);
      chk($sformatf("vec%0d_hled", v), 32'(led), 32'(vt[v].e_led));
      chk($sformatf("vec%0d_hnstb", v), 32'(nstb), 32'(vt[v].e_nstb));
      chk($sformatf("vec%0d_hrd", v), 32'(got[1]), 32'(vt[v].e_rd));
    end
    frame({8'h00, 8'h00, 8'hC3, 8'h01}, 1, 5, got);
    chk("abort_nstb", 32'(obs_q.size()), 32'h0);
    chk("abort_cmd_miso", 32'(got[0]), 32'h0);
    obs_q.delete();
    run_frame("abort_rb", {8'h00, 8'h00, 8'h00, 8'h81}, 2, got, nstb);
    chk("abort_rb_scr", 32'(got[1]), 32'(m_scr));
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(2, 4);
      b = $urandom;
      run_frame($sformatf("rnd%0d", r), b, n, got, nstb);
    end
    hp = 70;
    cs = 0;
    #(hp);
    shift_byte(8'h00, 3, g);
    @(posedge clk);
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    m_led = 0;
    m_scr = 0;
    m_cnt = 0;
    exp_q.delete();
    obs_q.delete();
    shift_byte(8'h00, 8, g);
    chk("rstmf_miso0", 32'(g), 32'h0);
    shift_byte(8'hF0, 8, g);
    chk("rstmf_miso1", 32'(g), 32'h0);
    #(hp);
    repeat (12) @(posedge clk);
    chk("rstmf_nstb", 32'(obs_q.size()), 32'h0);
    chk("rstmf_led", 32'(led), 32'h00);
    cs = 1;
    repeat (12) @(posedge clk);
    obs_q.delete();
    run_frame("post_rst", {8'h00, 8'h00, 8'hF0, 8'h00}, 2, got, nstb);
    chk("post_rst_hled", 32'(led), 32'hF0);
    chk("post_rst_hnstb", 32'(nstb), 32'h1);
    run_frame("post_rst_cnt", {8'h00, 8'h00, 8'h00, 8'h83}, 2, got, nstb);
    chk("post_rst_hcnt", 32'(got[1]), 32'h01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
